// File: rtl/vr_rr_mux_if.sv
// Valid/ready bundle for the round-robin arbiter-mux: NUM_CH input streams plus one merged output.
// The slave modport is the arbiter's view; master is the view of whoever drives the sources and sink.
interface vr_rr_mux_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4
);
  localparam int CHAN_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH-1:0]            in_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [CHAN_W-1:0]            out_chan;
  logic                         out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_chan, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_chan, out_last
  );
endinterface

// File: rtl/vr_rr_mux.sv
// N-channel valid/ready round-robin arbiter-multiplexer with a single registered output entry.
// Optional packet mode holds the grant on one channel from its first beat through its last beat.
module vr_rr_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int PKT_MODE   = 0
) (
  input logic        clk,
  input logic        rst,
  vr_rr_mux_if.slave bus
);
  localparam int CHAN_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t           state, state_nxt;
  logic [CHAN_W-1:0]     lock_ch, lock_ch_nxt;
  logic [CHAN_W-1:0]     last_grant;
  logic [CHAN_W-1:0]     grant;
  logic [NUM_CH-1:0]     lock_mask;
  logic [NUM_CH-1:0]     elig;
  logic [NUM_CH-1:0]     ready;
  logic                  found;
  logic                  load_ok;
  logic                  xfer;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [CHAN_W-1:0]     chan_p1;
  logic                  last_p1;

  // Stage 0: eligibility, round-robin search and handshake
  always_comb begin
    lock_mask          = '0;
    lock_mask[lock_ch] = 1'b1;
    elig               = (state == LOCKED) ? (bus.in_valid & lock_mask) : bus.in_valid;
  end

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && elig[(int'(last_grant) + 1 + i) % NUM_CH]) begin
        found = 1'b1;
        grant = CHAN_W'((int'(last_grant) + 1 + i) % NUM_CH);
      end
    end
  end

  // The same-cycle drain counts as free space, so a full register never forces a bubble.
  assign load_ok = !vld_p1 || bus.out_ready;
  assign xfer    = load_ok && found && !rst;

  always_comb begin
    ready = '0;
    if (xfer) ready[grant] = 1'b1;
  end

  assign bus.in_ready = ready;

  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    if (PKT_MODE != 0 && xfer) begin
      case (state)
        UNLOCKED: begin
          if (!bus.in_last[grant]) begin
            state_nxt   = LOCKED;
            lock_ch_nxt = grant;
          end
        end
        LOCKED: begin
          if (bus.in_last[grant]) state_nxt = UNLOCKED;
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= UNLOCKED;
      lock_ch    <= '0;
      last_grant <= CHAN_W'(NUM_CH - 1);
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
      if (xfer) last_grant <= grant;
    end
  end

  // Stage 1: single-entry output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= bus.in_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      chan_p1 <= grant;
      last_p1 <= (PKT_MODE != 0) ? bus.in_last[grant] : 1'b0;
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_chan  = chan_p1;
  assign bus.out_last  = last_p1;
endmodule

// File: doc/vr_rr_mux.md
# vr_rr_mux

Parametrised N-channel valid/ready arbiter-multiplexer. It merges NUM_CH independent valid/ready source streams into one registered valid/ready output stream using round-robin arbitration. An optional packet mode locks the grant until the end of a packet. It sits between several transmitters and a single receiver, and sustains one transfer per clock with a one-cycle latency.

## Interface
- DATA_WIDTH, 8: payload width per channel.
- NUM_CH, 4: number of input channels, 1..16.
- PKT_MODE, 0: 0 = beat arbitration; 1 = grant held from first beat through the beat with last=1.
- CHAN_W (localparam): max(1, $clog2(NUM_CH)).

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready.
- in_data  input  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- in_last  input  NUM_CH  end-of-packet flag per channel; ignored when PKT_MODE=0.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream ready.
- out_data  output  DATA_WIDTH  registered payload.
- out_chan  output  CHAN_W  source channel of out_data.
- out_last  output  1  registered copy of the source in_last; 0 when PKT_MODE=0.

## Operation
- Transfer on any channel occurs when valid && ready are both high at a rising clk edge.
- Sources must hold valid, data and last stable until accepted. The block holds out_valid, out_data, out_chan and out_last stable until accepted.
- The output register is a single entry. load_ok = !out_valid || out_ready.
- Eligibility:
  - PKT_MODE=0 or unlocked: every channel with in_valid=1 is eligible.
  - Locked: only lock_ch is eligible.
- Grant (combinational): the first eligible channel, searching from (last_grant+1) mod NUM_CH upward and wrapping.
- in_ready[g] = load_ok && (g == grant) && an eligible request exists. All other in_ready bits are 0.
  - in_ready may depend on in_valid. out_valid never depends on out_ready.
- On a transfer from channel g:
  - out_data <= in_data[g], out_chan <= g, out_last <= in_last[g] (PKT_MODE=1), out_valid <= 1, last_grant <= g.
- If out_valid && out_ready and no input transfer occurs, out_valid <= 0.
- Packet lock state machine (PKT_MODE=1 only):
  - States: UNLOCKED and LOCKED(lock_ch).
  - UNLOCKED -> LOCKED(g) on a transfer with in_last=0.
  - LOCKED -> UNLOCKED on a transfer from lock_ch with in_last=1.
  - A single-beat packet (last=1 on the first beat) stays UNLOCKED.
  - While LOCKED, other channels' in_valid is ignored even if lock_ch is idle. There is no timeout.
- NUM_CH=1: grant is always 0, out_chan is always 0, and the block behaves as a registered pipeline stage.

## Timing
- Reset values, applied immediately on rst rise and held while rst=1:
  - out_valid=0, out_data=0, out_chan=0, out_last=0.
  - in_ready all 0.
  - last_grant=NUM_CH-1, so channel 0 has first priority.
  - Lock state UNLOCKED.
- Reset deasserts synchronously to clk externally. The first transfer is possible on the first rising edge after rst falls.
- Latency: an input accepted at edge k appears on out_* after edge k. With out_ready held at 1, out_valid is 1 from edge k to edge k+1.
- Throughput: 1 beat/cycle while out_ready=1 and requests are present. There are no bubbles because load_ok includes the same-cycle drain.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready=0, outputs are frozen, and last_grant and lock state are unchanged.
- Simultaneous drain and load: the new beat replaces the old one in the same edge, and out_valid stays 1.
- Reset mid-packet clears the lock. Any beat held in the output register is discarded.
- Fairness: with all NUM_CH channels continuously valid, each channel is granted exactly once in every NUM_CH consecutive grants (PKT_MODE=0).

## Test plan
- Reset check: assert rst mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 and in_ready=0 immediately, before the next clk edge.
- Round-robin, NUM_CH=4, all in_valid=1, in_data[c]=8'hA0+c, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 and out_data A0,A1,A2,A3,A0; one beat per cycle.
- Backpressure: load 8'h55 from ch2, hold out_ready=0 for 3 cycles -> out_data=55 and out_chan=2 stable, in_ready=0000. Then out_ready=1 with ch3 valid -> 55 accepted and ch3 beat loaded on the same edge, out_valid stays 1.
- Sparse requests: only ch1 and ch3 valid, last_grant=1 -> grant order 3,1,3,1; channel 0 and channel 2 never receive in_ready.
- Packet lock, PKT_MODE=1: ch0 sends 3 beats (last=0,0,1) while ch1 is continuously valid -> out_chan=0,0,0 then 1; ch1 in_ready stays 0 until ch0's last beat transfers.
- Reset mid-packet: PKT_MODE=1, ch2 locked after 1 beat, pulse rst, then ch0 and ch2 both valid -> ch0 granted first, confirming the lock was cleared and last_grant was reset.
